// File: rtl/seg7_io_ctrl.sv
// seg7_io_ctrl -- memory-mapped 8-digit seven-segment display controller.
//
// A bus write to the value register either converts the 16-bit value to
// five BCD digits (decimal mode, 16-cycle double-dabble) or shows it as four
// hex digits straight away (hex mode). The digits are scanned one at a time
// by a free-running divider.
//
// Ports:
//   clock     in   1   system clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   segwrite  in   1   write strobe from the memory/IO bus
//   segcs     in   1   chip select
//   segaddr   in   2   00 value register, 01 control register, 1x reserved
//   segwdata  in  16   write data
//   busy      out  1   binary-to-BCD conversion in progress
//   seg_en    out  8   digit enables, active-low, bit i = digit i
//   seg_out   out  8   segments, active-low, bit0..6 = a..g, bit7 = dp
//
// Bus handshake: there is no ready. A write is taken on any rising edge where
// segwrite=1 and segcs=1; one such edge is exactly one write. A value write
// while busy restarts the conversion with the new value.
module seg7_io_ctrl #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        segwrite,
    input  logic        segcs,
    input  logic [1:0]  segaddr,
    input  logic [15:0] segwdata,
    output logic        busy,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    // Display entry: {blank, nibble}
    localparam logic [4:0] BLANK = 5'b1_0000;

    // Control: bit0 display enable, bit1 hex mode
    logic [1:0]       r_ctrl;
    // Value register; doubles as the binary shift source during conversion
    logic [15:0]      r_value;
    logic [19:0]      r_bcd;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic [4:0]       r_disp [0:7];
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [7:0]       r_seg_out;

    logic             w_wr_val;
    logic             w_wr_ctl;
    logic             w_mode_chg;
    logic [19:0]      w_bcd_adj;
    logic [19:0]      w_bcd_next;
    logic [4:0]       w_dec_disp [0:7];
    logic             w_lead;
    logic             w_wrap;
    logic [2:0]       w_idx_next;

    function automatic logic [7:0] f_encode(input logic [4:0] d);
        logic [7:0] s;
        if (d[4]) begin
            s = 8'hFF;
        end else begin
            case (d[3:0])
                4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
                4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
                4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
                4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
            endcase
        end
        return s;
    endfunction

    assign w_wr_val   = segwrite & segcs & (segaddr == 2'b00);
    assign w_wr_ctl   = segwrite & segcs & (segaddr == 2'b01);
    assign w_mode_chg = w_wr_ctl & (segwdata[1] != r_ctrl[1]);

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift the
    // next binary bit in. A value <= 65535 never sets bit 19 of r_bcd.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < 5; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
        w_bcd_next = (w_bcd_adj << 1) | {19'd0, r_value[15]};
    end

    // Decimal digit image with leading zeros blanked; digit 0 always shown.
    always_comb begin
        w_lead = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_dec_disp[i] = BLANK;
        end
        for (int i = 4; i >= 1; i--) begin
            if (w_lead && (w_bcd_next[4*i +: 4] == 4'd0)) begin
                w_dec_disp[i] = BLANK;
            end else begin
                w_dec_disp[i] = {1'b0, w_bcd_next[4*i +: 4]};
                w_lead        = 1'b0;
            end
        end
        w_dec_disp[0] = {1'b0, w_bcd_next[3:0]};
    end

    // Registers, conversion and display image
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_ctrl  <= 2'b01;
            r_value <= 16'd0;
            r_bcd   <= 20'd0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_disp[0] <= 5'b0_0000;
            for (int i = 1; i < 8; i++) begin
                r_disp[i] <= BLANK;
            end
        end else begin
            if (w_wr_ctl) begin
                r_ctrl <= segwdata[1:0];
            end
            if (w_wr_val) begin
                r_value <= segwdata;
                if (r_ctrl[1]) begin
                    r_busy <= 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        r_disp[i] <= {1'b0, segwdata[4*i +: 4]};
                    end
                    for (int i = 4; i < 8; i++) begin
                        r_disp[i] <= BLANK;
                    end
                end else begin
                    // Start (or restart) the conversion; last write wins
                    r_bcd  <= 20'd0;
                    r_cnt  <= 4'd0;
                    r_busy <= 1'b1;
                end
            end else if (w_mode_chg) begin
                // Abandon the conversion; the display keeps its old digits
                r_busy <= 1'b0;
            end else if (r_busy) begin
                r_value <= r_value << 1;
                r_bcd   <= w_bcd_next;
                r_cnt   <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    // Final step: publish all digits at once
                    r_busy <= 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        r_disp[i] <= w_dec_disp[i];
                    end
                end
            end
        end
    end

    // Scan divider and digit index
    assign w_wrap     = (r_div == DIV_LAST);
    assign w_idx_next = w_wrap ? r_idx + 3'd1 : r_idx;

    // seg_out is encoded for the index the register will hold after this
    // edge, so it lines up with seg_en on the same cycle.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_idx     <= 3'd0;
            r_seg_out <= 8'hC0;
        end else begin
            r_div     <= w_wrap ? '0 : r_div + DIV_W'(1);
            r_idx     <= w_idx_next;
            r_seg_out <= f_encode(r_disp[w_idx_next]);
        end
    end

    assign busy    = r_busy;
    assign seg_out = r_seg_out;
    assign seg_en  = r_ctrl[0] ? ~(8'h01 << r_idx) : 8'hFF;

endmodule

// File: tb/tb_seg7_io_ctrl.sv
// Directed bench for seg7_io_ctrl with SCAN_DIV=4.
module tb_seg7_io_ctrl;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        segwrite = 1'b0;
  logic        segcs = 1'b0;
  logic [1:0]  segaddr = 2'b00;
  logic [15:0] segwdata = 16'd0;
  logic        busy;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic mon_en = 1'b0;
  logic saw_bad = 1'b0;

  seg7_io_ctrl #(.SCAN_DIV(4)) dut (
    .clock    (clock),
    .rst      (rst),
    .segwrite (segwrite),
    .segcs    (segcs),
    .segaddr  (segaddr),
    .segwdata (segwdata),
    .busy     (busy),
    .seg_en   (seg_en),
    .seg_out  (seg_out)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // While armed, flags any segment code belonging to 65535 (digits 5,3,6)
  always @(negedge clock) begin
    if (mon_en && (seg_out == 8'h92 || seg_out == 8'hB0 || seg_out == 8'h82))
      saw_bad = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic cs, input logic [1:0] a, input logic [15:0] d);
    @(negedge clock);
    segwrite = 1'b1;
    segcs    = cs;
    segaddr  = a;
    segwdata = d;
    @(negedge clock);
    segwrite = 1'b0;
    segcs    = 1'b0;
  endtask

  task automatic busy_run(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic get_digit(input int i, output logic [7:0] s);
    logic [7:0] want;
    bit found;
    want  = ~(8'h01 << i);
    found = 1'b0;
    s     = 8'h00;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clock);
      if (seg_en === want) begin
        s     = seg_out;
        found = 1'b1;
      end
    end
  endtask

  // exp packs digit 7 in the top byte down to digit 0 in the bottom byte
  task automatic check_disp(input string tag, input logic [63:0] exp);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) begin
      get_digit(i, s);
      chk($sformatf("%s_d%0d", tag, i), s, exp[8*i +: 8]);
    end
  endtask

  initial begin
    int n;
    int c_en;
    int c_f8;
    int c_ff;
    logic [7:0] s;
    logic [7:0] exp_en;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_seg_en", seg_en, 8'hFE);
    chk("rst_seg_out", seg_out, 8'hC0);

    // idle scan after release: digit index advances every 4 cycles
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      exp_en = ~(8'h01 << ((k / 4) % 8));
      chk($sformatf("idle_en_%0d", k), seg_en, exp_en);
      chk($sformatf("idle_out_%0d", k), seg_out, (((k / 4) % 8) == 0) ? 8'hC0 : 8'hFF);
      chk($sformatf("idle_busy_%0d", k), busy, 1'b0);
      @(negedge clock);
    end

    // decimal 12345
    bus_write(1'b1, 2'b00, 16'd12345);
    busy_run(n);
    chk("dec_busy_len", n, 16);
    check_disp("dec12345", 64'hFFFF_FFF9_A4B0_9992);

    // hex BEEF
    bus_write(1'b1, 2'b01, 16'd3);
    bus_write(1'b1, 2'b00, 16'hBEEF);
    chk("hex_busy", busy, 1'b0);
    check_disp("hexbeef", 64'hFFFF_FFFF_8386_868E);
    chk("hex_busy_after", busy, 1'b0);

    // back to decimal: display untouched until the next value write
    bus_write(1'b1, 2'b01, 16'd1);
    chk("mode_nobusy", busy, 1'b0);
    get_digit(0, s);
    chk("mode_keep_d0", s, 8'h8E);

    // 65535 then 7 restart
    mon_en  = 1'b1;
    saw_bad = 1'b0;
    bus_write(1'b1, 2'b00, 16'd65535);
    repeat (4) @(negedge clock);
    bus_write(1'b1, 2'b00, 16'd7);
    busy_run(n);
    chk("restart_busy_len", n, 16);
    check_disp("dec7", 64'hFFFF_FFFF_FFFF_FFF8);
    mon_en = 1'b0;
    chk("never_65535", saw_bad, 1'b0);

    // ignored writes: no chip select, reserved addresses
    bus_write(1'b0, 2'b00, 16'd99);
    chk("nocs_busy", busy, 1'b0);
    bus_write(1'b1, 2'b10, 16'h0000);
    chk("addr10_busy", busy, 1'b0);
    bus_write(1'b1, 2'b11, 16'h0002);
    chk("addr11_busy", busy, 1'b0);
    check_disp("ignored", 64'hFFFF_FFFF_FFFF_FFF8);

    // mode change while converting aborts and keeps the display
    bus_write(1'b1, 2'b00, 16'd500);
    repeat (3) @(negedge clock);
    chk("abort_pre_busy", busy, 1'b1);
    bus_write(1'b1, 2'b01, 16'd3);
    chk("abort_busy", busy, 1'b0);
    repeat (20) @(negedge clock);
    chk("abort_busy_later", busy, 1'b0);
    check_disp("abort", 64'hFFFF_FFFF_FFFF_FFF8);
    bus_write(1'b1, 2'b01, 16'd1);

    // display disabled: enables all high, segments still scanned
    bus_write(1'b1, 2'b01, 16'd0);
    c_en = 0;
    c_f8 = 0;
    c_ff = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      if (seg_en !== 8'hFF) c_en++;
      if (seg_out === 8'hF8) c_f8++;
      if (seg_out === 8'hFF) c_ff++;
    end
    chk("dis_en_count", c_en, 0);
    chk("dis_f8_count", c_f8, 4);
    chk("dis_ff_count", c_ff, 28);
    bus_write(1'b1, 2'b01, 16'd1);

    // reset in the middle of a conversion
    bus_write(1'b1, 2'b00, 16'd999);
    repeat (7) @(negedge clock);
    chk("midrst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_seg_en", seg_en, 8'hFE);
    chk("midrst_seg_out", seg_out, 8'hC0);
    repeat (2) @(negedge clock);
    // write presented together with the release: taken on the first edge
    rst      = 1'b0;
    segwrite = 1'b1;
    segcs    = 1'b1;
    segaddr  = 2'b00;
    segwdata = 16'd42;
    @(negedge clock);
    segwrite = 1'b0;
    segcs    = 1'b0;
    busy_run(n);
    chk("post_rst_busy_len", n, 16);
    check_disp("dec42", 64'hFFFF_FFFF_FFFF_99A4);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
